// File: rtl/mem_ctrl.sv
// Burst memory controller: turns single-cycle processor requests into 4-beat
// critical-word-first bursts that wrap inside a 4-word aligned block.
module mem_ctrl #(
    parameter  int MEMSIZE   = 256,
    parameter  int BUSWIDTH  = 16,
    localparam int ADDRWIDTH = $clog2(MEMSIZE)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req,
    input  logic                 rw_n,
    input  logic [ADDRWIDTH-1:0] addr,
    input  logic [BUSWIDTH-1:0]  wdata,
    output logic                 ready,
    output logic [BUSWIDTH-1:0]  rdata,
    output logic                 rvalid,
    output logic                 done,
    output logic [ADDRWIDTH-1:0] mem_Addr,
    output logic [BUSWIDTH-1:0]  mem_DataIn,
    output logic                 mem_rdEn,
    output logic                 mem_wrEn,
    input  logic [BUSWIDTH-1:0]  mem_DataOut
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t                 state;
    logic [ADDRWIDTH-1:0]   base;
    logic [1:0]             beat;
    logic [1:0]             low;
    logic [ADDRWIDTH-1:0]   beat_addr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            base   <= '0;
            beat   <= '0;
            rdata  <= '0;
            rvalid <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rvalid <= 1'b0;
                    done   <= 1'b0;
                    if (req) begin
                        base  <= addr;
                        beat  <= '0;
                        state <= rw_n ? READ : WRITE;
                    end
                end
                READ: begin
                    rdata  <= mem_DataOut;
                    rvalid <= 1'b1;
                    beat   <= beat + 2'd1;
                    done   <= (beat == 2'd3);
                    if (beat == 2'd3) state <= IDLE;
                end
                WRITE: begin
                    rvalid <= 1'b0;
                    beat   <= beat + 2'd1;
                    done   <= (beat == 2'd3);
                    if (beat == 2'd3) state <= IDLE;
                end
                default: begin
                    rvalid <= 1'b0;
                    done   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Low two bits add mod 4 so the burst wraps within its aligned block.
    always_comb begin
        ready      = (state == IDLE);
        low        = base[1:0] + beat;
        beat_addr  = {base[ADDRWIDTH-1:2], low};
        mem_Addr   = '0;
        mem_DataIn = '0;
        mem_rdEn   = 1'b0;
        mem_wrEn   = 1'b0;
        case (state)
            READ: begin
                mem_rdEn = 1'b1;
                mem_Addr = beat_addr;
            end
            WRITE: begin
                mem_wrEn   = 1'b1;
                mem_Addr   = beat_addr;
                mem_DataIn = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomised self-checking bench for mem_ctrl with a behavioural memory and
// a reference image of what the memory should hold.
module tb_mem_ctrl;

    localparam int MEMSIZE = 256;
    localparam int BW      = 16;
    localparam int AW      = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req = 1'b0;
    logic          rw_n = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [BW-1:0] wdata = '0;
    logic          ready, rvalid, done, mem_rdEn, mem_wrEn;
    logic [BW-1:0] rdata, mem_DataIn, mem_DataOut;
    logic [AW-1:0] mem_Addr;

    logic [BW-1:0] mem     [MEMSIZE];
    logic [BW-1:0] ref_mem [MEMSIZE];

    int errors = 0;
    int checks = 0;
    int both_cnt = 0;

    mem_ctrl #(.MEMSIZE(MEMSIZE), .BUSWIDTH(BW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .rw_n       (rw_n),
        .addr       (addr),
        .wdata      (wdata),
        .ready      (ready),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .done       (done),
        .mem_Addr   (mem_Addr),
        .mem_DataIn (mem_DataIn),
        .mem_rdEn   (mem_rdEn),
        .mem_wrEn   (mem_wrEn),
        .mem_DataOut(mem_DataOut)
    );

    always #5 clk = ~clk;

    assign mem_DataOut = mem_rdEn ? mem[mem_Addr] : '0;

    always @(posedge clk) begin
        if (mem_wrEn) mem[mem_Addr] <= mem_DataIn;
        if (mem_wrEn && mem_rdEn) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Address of beat k for a burst starting at a: block base plus (a+k) mod 4.
    function automatic logic [AW-1:0] burst_addr(input logic [AW-1:0] a, input int k);
        int blk;
        blk = int'(a) - (int'(a) % 4);
        return AW'(blk + ((int'(a) + k) % 4));
    endfunction

    task automatic write_burst(input logic [AW-1:0] a, input logic [BW-1:0] d0, d1, d2, d3);
        logic [BW-1:0] d [4];
        d = '{d0, d1, d2, d3};
        check("wr_ready_before", ready, 1);
        req = 1'b1; rw_n = 1'b0; addr = a;
        @(posedge clk); #1;
        req = 1'b0; addr = AW'($urandom);
        for (int k = 0; k < 4; k++) begin
            wdata = d[k];
            #1;
            check("wr_ready_busy", ready, 0);
            check("wr_wren", mem_wrEn, 1);
            check("wr_rden", mem_rdEn, 0);
            check("wr_addr", mem_Addr, burst_addr(a, k));
            check("wr_data", mem_DataIn, d[k]);
            check("wr_done_early", done, 0);
            ref_mem[burst_addr(a, k)] = d[k];
            @(posedge clk); #1;
        end
        check("wr_done", done, 1);
        check("wr_ready_after", ready, 1);
        check("wr_idle_wren", mem_wrEn, 0);
    endtask

    task automatic read_burst(input logic [AW-1:0] a, input bit poke, input bit chain,
                              input logic [AW-1:0] next_a);
        logic [BW-1:0] exp [4];
        for (int k = 0; k < 4; k++) exp[k] = ref_mem[burst_addr(a, k)];
        check("rd_ready_before", ready, 1);
        req = 1'b1; rw_n = 1'b1; addr = a;
        @(posedge clk); #1;
        req = 1'b0;
        check("rd_gap_rvalid", rvalid, 0);
        check("rd_rden", mem_rdEn, 1);
        check("rd_wren", mem_wrEn, 0);
        check("rd_addr", mem_Addr, burst_addr(a, 0));
        check("rd_ready_busy", ready, 0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("rd_rvalid", rvalid, 1);
            check("rd_data", rdata, exp[k]);
            if (k < 3) begin
                check("rd_addr", mem_Addr, burst_addr(a, k + 1));
                check("rd_done_early", done, 0);
                check("rd_ready_busy", ready, 0);
            end else begin
                check("rd_done", done, 1);
                check("rd_ready_after", ready, 1);
            end
            if (poke && k == 0) begin
                req = 1'b1; rw_n = 1'b0; addr = 8'h40;
            end
            if (poke && k == 1) req = 1'b0;
        end
        if (chain) begin
            req = 1'b1; rw_n = 1'b1; addr = next_a;
        end
    endtask

    initial begin
        logic [BW-1:0] v;
        logic [BW-1:0] keep24;
        logic [AW-1:0] ra, na;
        bit            chained;
        int            mism;

        for (int i = 0; i < MEMSIZE; i++) begin
            v = BW'($urandom);
            mem[i] <= v;
            ref_mem[i] = v;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", ready, 1);
        check("rst_rvalid", rvalid, 0);
        check("rst_done", done, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rden", mem_rdEn, 0);
        check("rst_wren", mem_wrEn, 0);
        check("rst_addr", mem_Addr, 0);
        check("rst_datain", mem_DataIn, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Aligned write then read
        write_burst(8'h10, 16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3);
        read_burst(8'h10, 1'b0, 1'b0, 8'h00);

        // Wrap-around
        keep24 = ref_mem[8'h24];
        write_burst(8'h22, 16'd1, 16'd2, 16'd3, 16'd4);
        @(posedge clk); #1;
        check("wrap_m22", mem[8'h22], 1);
        check("wrap_m23", mem[8'h23], 2);
        check("wrap_m20", mem[8'h20], 3);
        check("wrap_m21", mem[8'h21], 4);
        check("wrap_m24", mem[8'h24], keep24);
        read_burst(8'h23, 1'b0, 1'b0, 8'h00);

        // Top of memory
        write_burst(8'hFF, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
        @(posedge clk); #1;
        check("top_mff", mem[8'hFF], 16'h1111);
        check("top_mfc", mem[8'hFC], 16'h2222);
        check("top_mfd", mem[8'hFD], 16'h3333);
        check("top_mfe", mem[8'hFE], 16'h4444);

        // Busy request ignored
        read_burst(8'h10, 1'b1, 1'b0, 8'h00);
        @(posedge clk); #1;
        check("busy_ready", ready, 1);
        check("busy_m40", mem[8'h40], ref_mem[8'h40]);

        // Back-to-back reads
        read_burst(8'h10, 1'b0, 1'b1, 8'h20);
        read_burst(8'h20, 1'b0, 1'b0, 8'h00);

        // Mid-write reset: beats 0..2 land (beat 2 shares the reset edge), beat 3 never does
        @(posedge clk); #1;
        req = 1'b1; rw_n = 1'b0; addr = 8'h31;
        @(posedge clk); #1;
        req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wdata = BW'(16'h5A00 + k);
            ref_mem[burst_addr(8'h31, k)] = wdata;
            if (k == 2) reset_n = 1'b0;
            else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        wdata = 16'hDEAD;
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            check("rrel_ready", ready, 1);
            check("rrel_rvalid", rvalid, 0);
            check("rrel_done", done, 0);
            check("rrel_wren", mem_wrEn, 0);
            check("rrel_rden", mem_rdEn, 0);
            @(posedge clk); #1;
        end
        check("rrel_m30", mem[8'h30], ref_mem[8'h30]);
        check("rrel_m33", mem[8'h33], 16'h5A02);

        // Randomised bursts
        chained = 1'b0;
        na = '0;
        for (int it = 0; it < 40; it++) begin
            ra = chained ? na : AW'($urandom);
            if (chained || ($urandom % 2) == 1) begin
                chained = (($urandom % 3) == 0);
                na = AW'($urandom);
                read_burst(ra, 1'b0, chained, na);
            end else begin
                write_burst(ra, BW'($urandom), BW'($urandom), BW'($urandom), BW'($urandom));
            end
        end
        @(posedge clk); #1;

        mism = 0;
        for (int i = 0; i < MEMSIZE; i++)
            if (mem[i] !== ref_mem[i]) mism++;
        check("mem_image_mismatches", mism, 0);
        check("rden_wren_both", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Burst memory controller: the initiator on the memory-controller interface that drives the synchronous R/W memory array. Accepts single-cycle read or write requests from a processor-side port and converts each into a fixed 4-beat burst of memory accesses, with critical-word-first wrap within a 4-word aligned block. Sits between the processor bus model and the memory array, owning `Addr`, `DataIn`, `rdEn` and `wrEn`, and consuming `DataOut`.

## Interface

Parameters:
- `MEMSIZE`, 256: memory depth in words (power of 2, ≥ 4).
- `BUSWIDTH`, 16: data word width.
- `ADDRWIDTH`, `$clog2(MEMSIZE)`: derived local parameter; not overridable.

Ports. Single clock `clk`; reset is synchronous and active-low on `reset_n`.

- `clk` in 1: clock. Shared with the memory `clk`.
- `reset_n` in 1: synchronous active-low reset.
- `req` in 1: request strobe. Sampled only when `ready`=1.
- `rw_n` in 1: 1=read burst, 0=write burst. Sampled with `req`.
- `addr` in ADDRWIDTH: start word address. Sampled with `req`.
- `wdata` in BUSWIDTH: write beat data. Consumed one beat per cycle during WRITE.
- `ready` out 1: 1 only in IDLE.
- `rdata` out BUSWIDTH: read beat data (registered).
- `rvalid` out 1: `rdata` valid this cycle.
- `done` out 1: one-cycle pulse at burst completion.
- `mem_Addr` out ADDRWIDTH: memory address.
- `mem_DataIn` out BUSWIDTH: memory write data.
- `mem_rdEn` out 1: memory read enable.
- `mem_wrEn` out 1: memory write enable.
- `mem_DataOut` in BUSWIDTH: memory read data. Combinational from `mem_Addr` while `mem_rdEn`=1.

## Operation

- FSM states: IDLE, READ, WRITE.
  - IDLE→READ on `req`&`rw_n`.
  - IDLE→WRITE on `req`&!`rw_n`.
  - READ/WRITE→IDLE after beat 3.
- On acceptance, register `base`=`addr` and clear the 2-bit beat counter `beat`.
- `beat` increments each cycle in READ/WRITE.
- Beat address: `{base[ADDRWIDTH-1:2], base[1:0]+beat}`. Lower 2 bits are mod-4, so the burst wraps inside its aligned block and never crosses it.
- READ: `mem_rdEn`=1, `mem_wrEn`=0, `mem_Addr`=beat address.
  - `rdata` <= `mem_DataOut` and `rvalid` <= 1 at each clock edge in READ; otherwise `rvalid` <= 0 and `rdata` holds its value.
- WRITE: `mem_wrEn`=1, `mem_rdEn`=0, `mem_Addr`=beat address, `mem_DataIn`=`wdata` (combinational pass-through). Memory captures at the end of the cycle.
- IDLE: `mem_rdEn`=`mem_wrEn`=0, `mem_Addr`=0, `mem_DataIn`=0.
- `mem_rdEn` and `mem_wrEn` are decoded from the registered state and are never both 1.
- Requests while `ready`=0 are ignored: no queuing, no error.
- Reset (`reset_n`=0 at an edge): state→IDLE, `beat`=0, `base`=0, `rdata`=0, `rvalid`=0, `done`=0.
  - So after reset: `ready`=1 and all `mem_*` outputs 0.
  - Mid-burst reset aborts the remaining beats. Words already written stay in memory.

## Timing

- Request accepted at edge T (`req`=1, `ready`=1). Cycles T+1..T+4 are beats 0..3. Back in IDLE from T+5.
- Write: processor drives `wdata` for beat k during cycle T+1+k. Memory updated at the edges ending T+1..T+4. `done`=1 during T+5.
- Read: `rvalid`=1 with beat k data during cycle T+2+k (cycles T+2..T+5). `done`=1 during T+5, coincident with the last `rvalid`.
- `ready`=1 during T+5, so a new request can be accepted at the end of T+5. Back-to-back throughput: 1 burst per 5 cycles.
- A new request accepted at the end of T+5 does not disturb the final `rvalid` or `done` of the previous burst.

## Test plan

- Reset: hold `reset_n`=0 two cycles mid-WRITE.
  - Required: `ready`=1, `rvalid`=0, `done`=0, `mem_wrEn`=`mem_rdEn`=0 on the cycle after release.
  - Required: words written after the reset edge are unchanged.
- Aligned write then read:
  - Write burst `addr`=0x10, data 0xA0A0, 0xB1B1, 0xC2C2, 0xD3D3.
  - Then read burst `addr`=0x10.
  - Required: `rvalid` on 4 consecutive cycles with the same 4 words in order, and `done` on the last.
- Wrap-around:
  - Write burst `addr`=0x22, data 1,2,3,4.
  - Required: M[0x22]=1, M[0x23]=2, M[0x20]=3, M[0x21]=4, and M[0x24] is untouched.
  - A read at `addr`=0x23 returns 2,3,4,1.
- Top of memory: write burst `addr`=MEMSIZE-1 = 0xFF.
  - Required addresses: 0xFF, 0xFC, 0xFD, 0xFE.
  - Required: no access outside 0xFC..0xFF.
- Busy request ignored: pulse `req`=1 with `rw_n`=0 and `addr`=0x40 during a read burst.
  - Required: the read completes normally, no write to 0x40, and `ready` returns at T+5.
- Back-to-back: read burst at 0x10, new read `req` at 0x20 on the cycle `done`=1.
  - Required: 8 `rvalid` beats with a 1-cycle gap between them.
  - Required: `mem_rdEn` and `mem_wrEn` are never both 1.
